// File: rtl/ltc2175_frame_align.sv
// ltc2175_frame_align
// Bring-up sequencer for the LTC2175 LVDS capture path, clocked in the divided
// capture domain. Pulses the BUFR clear, waits for the ISERDES to settle, then
// bitslips until the frame lane shows FRAME_PATTERN for MATCH_CNT consecutive
// words. Reports locked / fail to the host.
// Optional feature: define LTC2175_ALIGN_MONITOR_EN to enable the in-lock
// error monitor (ERR_LIMIT consecutive bad frame words trigger a relock).
module ltc2175_frame_align #(
    parameter int unsigned        FRAME_W       = 8,
    parameter logic [FRAME_W-1:0] FRAME_PATTERN = 8'hF0,
    parameter int unsigned        CLR_CYCLES    = 4,
    parameter int unsigned        SETTLE_CYCLES = 16,
    parameter int unsigned        MATCH_CNT     = 16,
    parameter int unsigned        MAX_SLIPS     = 8,
    parameter int unsigned        ERR_LIMIT     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_word,
    output logic               bufr_clr,
    output logic               bitslip,
    output logic               locked,
    output logic               fail,
    output logic [7:0]         slip_cnt,
    output logic [7:0]         relock_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_e;

    // One shared delay counter serves both the clear pulse and the settle wait.
    localparam int unsigned CNT_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned MATCH_W = $clog2(MATCH_CNT + 1);
    localparam int unsigned ERR_W   = $clog2(ERR_LIMIT + 1);

    localparam logic [CNT_W-1:0]   CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(MATCH_CNT - 1);
    localparam logic [7:0]         SLIP_LIMIT  = 8'(MAX_SLIPS);
`ifdef LTC2175_ALIGN_MONITOR_EN
    localparam logic [ERR_W-1:0]   ERR_LAST    = ERR_W'(ERR_LIMIT - 1);
`endif

    state_e             state, next_state;
    logic [FRAME_W-1:0] word_q;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [MATCH_W-1:0] match_cnt, match_cnt_d;
    logic [ERR_W-1:0]   err_cnt, err_cnt_d;
    logic [7:0]         slip_cnt_d, relock_cnt_d;
    logic               bufr_clr_d, bitslip_d, locked_d, fail_d;
    logic               word_match;
    logic               slips_exhausted;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Compare against the registered frame word (one cycle of input latency).
    assign word_match      = (word_q == FRAME_PATTERN);
    assign slips_exhausted = (slip_cnt == SLIP_LIMIT);

    // State, datapath and output registers; every output comes straight from a flop.
    // NOTE: non-blocking assignments make every flop sample pre-edge values, and the
    // async reset drops bufr_clr/bitslip at once so no partial pulse outlives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            word_q     <= '0;
            cnt        <= '0;
            match_cnt  <= '0;
            err_cnt    <= '0;
            slip_cnt   <= '0;
            relock_cnt <= '0;
            bufr_clr   <= 1'b0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= next_state;
            word_q     <= frame_word;
            cnt        <= cnt_d;
            match_cnt  <= match_cnt_d;
            err_cnt    <= err_cnt_d;
            slip_cnt   <= slip_cnt_d;
            relock_cnt <= relock_cnt_d;
            bufr_clr   <= bufr_clr_d;
            bitslip    <= bitslip_d;
            locked     <= locked_d;
            fail       <= fail_d;
        end
    end

    // Next-state selection; start overrides every other transition.
    // NOTE: next_state is defaulted before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = S_CLR;
        end else begin
            case (state)
                S_IDLE:   next_state = S_IDLE;
                S_CLR:    if (cnt == CLR_LAST) next_state = S_SETTLE;
                S_SETTLE: if (cnt == SETTLE_LAST) next_state = S_CHECK;
                S_CHECK: begin
                    if (!word_match)                next_state = S_SLIP;
                    else if (match_cnt == MATCH_LAST) next_state = S_LOCKED;
                end
                S_SLIP:   next_state = slips_exhausted ? S_FAIL : S_SETTLE;
                S_LOCKED: begin
`ifdef LTC2175_ALIGN_MONITOR_EN
                    if (!word_match && err_cnt == ERR_LAST) next_state = S_SETTLE;
`endif
                end
                S_FAIL:   next_state = S_FAIL;
                default:  next_state = S_IDLE;
            endcase
        end
    end

    // Counter updates and next output values, registered above.
    always_comb begin
        cnt_d        = cnt;
        match_cnt_d  = match_cnt;
        err_cnt_d    = err_cnt;
        slip_cnt_d   = slip_cnt;
        relock_cnt_d = relock_cnt;
        bitslip_d    = 1'b0;
        bufr_clr_d   = (next_state == S_CLR);
        locked_d     = (next_state == S_LOCKED);
        fail_d       = (next_state == S_FAIL);
        if (start) begin
            cnt_d       = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            slip_cnt_d  = '0;
        end else begin
            case (state)
                S_CLR:    cnt_d = (cnt == CLR_LAST) ? '0 : cnt + CNT_W'(1);
                S_SETTLE: begin
                    cnt_d       = (cnt == SETTLE_LAST) ? '0 : cnt + CNT_W'(1);
                    match_cnt_d = '0;
                end
                S_CHECK: begin
                    err_cnt_d = '0;
                    if (word_match) match_cnt_d = match_cnt + MATCH_W'(1);
                end
                S_SLIP: begin
                    cnt_d = '0;
                    // The pulse lands in the first settle cycle, so it can never repeat back-to-back.
                    if (!slips_exhausted) begin
                        bitslip_d  = 1'b1;
                        slip_cnt_d = sat_inc(slip_cnt);
                    end
                end
                S_LOCKED: begin
`ifdef LTC2175_ALIGN_MONITOR_EN
                    if (word_match) begin
                        err_cnt_d = '0;
                    end else if (err_cnt == ERR_LAST) begin
                        err_cnt_d    = '0;
                        cnt_d        = '0;
                        slip_cnt_d   = '0;
                        relock_cnt_d = sat_inc(relock_cnt);
                    end else begin
                        err_cnt_d = err_cnt + ERR_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2175_frame_align.sv
// Testbench for ltc2175_frame_align: a frame-lane model rotates its word one bit
// per bitslip; a reference model predicts the event sequence (clear pulse, slips,
// lock/fail/unlock) per start, and a negedge monitor compares observed events.
module tb_ltc2175_frame_align;

  localparam int         CLR_CYCLES    = 4;
  localparam int         SETTLE_CYCLES = 16;
  localparam int         MATCH_CNT     = 16;
  localparam int         MAX_SLIPS     = 8;
  localparam int         ERR_LIMIT     = 4;
  localparam logic [7:0] PATTERN       = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_word = 8'h00;
  logic       bufr_clr, bitslip, locked, fail;
  logic [7:0] slip_cnt, relock_cnt;

  always #5 clk = ~clk;

  ltc2175_frame_align #(
    .FRAME_W(8), .FRAME_PATTERN(PATTERN), .CLR_CYCLES(CLR_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .MATCH_CNT(MATCH_CNT),
    .MAX_SLIPS(MAX_SLIPS), .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_word(frame_word),
    .bufr_clr(bufr_clr), .bitslip(bitslip), .locked(locked), .fail(fail),
    .slip_cnt(slip_cnt), .relock_cnt(relock_cnt)
  );

  typedef enum int {EV_CLR, EV_SLIP, EV_LOCK, EV_FAIL, EV_UNLOCK} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;     // clear width for EV_CLR, {locked,fail} otherwise
    int       slip;
    int       relock;
    int       lat;     // cycles since the start edge, -1 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  bit  mon_en = 1'b0;

  // frame lane model
  logic [7:0] base = PATTERN;
  int         rot = 0;
  bit         aa_mode = 1'b0;
  bit         corrupt = 1'b0;

  // reference model state
  bit model_locked = 1'b0;
  int exp_relock = 0;

  // monitor state
  int clr_w = 0;
  int last_slip = -1;
  bit p_clr = 1'b0, p_slip = 1'b0, p_lock = 1'b0, p_fail = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < n % 8; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e k, input int val, input int slip, input int lat);
    ev_t e;
    e.kind = k; e.val = val; e.slip = slip; e.relock = exp_relock; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Reference model: which events one alignment run must produce, from the current lane word.
  task automatic predict();
    logic [7:0] w;
    int n, nslip;
    w = aa_mode ? 8'hAA : rotl(base, rot);
    n = -1;
    for (int i = 0; i <= MAX_SLIPS; i++)
      if (n < 0 && rotl(w, i) == PATTERN) n = i;
    nslip = (n < 0) ? MAX_SLIPS : n;
    push(EV_CLR, CLR_CYCLES, 0, CLR_CYCLES);
    for (int i = 1; i <= nslip; i++)
      push(EV_SLIP, 0, i, CLR_CYCLES + i * (SETTLE_CYCLES + 2));
    if (n >= 0) begin
      push(EV_LOCK, 2, n, CLR_CYCLES + SETTLE_CYCLES + MATCH_CNT + n * (SETTLE_CYCLES + 2));
      model_locked = 1'b1;
    end else begin
      push(EV_FAIL, 1, MAX_SLIPS, CLR_CYCLES + SETTLE_CYCLES + MAX_SLIPS * (SETTLE_CYCLES + 2) + 2);
    end
  endtask

  task automatic pulse_start(input logic [7:0] new_base, input bit new_aa);
    @(posedge clk); #1;
    base = new_base; rot = 0; aa_mode = new_aa;
    start = 1'b1;
    start_cyc = cyc + 1;
    if (model_locked) push(EV_UNLOCK, 0, 0, 0);
    model_locked = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] new_base, input bit new_aa);
    pulse_start(new_base, new_aa);
    predict();
  endtask

  task automatic wait_q(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    check({name, "_events_done"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic feed(input logic [15:0] pat, input int len);
    for (int i = 0; i < len; i++) begin @(posedge clk); #1; corrupt = pat[i]; end
  endtask

  task automatic chk_reset(input string pfx);
    check({pfx, "_bufr_clr"}, bufr_clr, 0);
    check({pfx, "_bitslip"}, bitslip, 0);
    check({pfx, "_locked"}, locked, 0);
    check({pfx, "_fail"}, fail, 0);
    check({pfx, "_slip_cnt"}, slip_cnt, 0);
    check({pfx, "_relock_cnt"}, relock_cnt, 0);
  endtask

  task automatic got(input ev_kind_e k, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got %s expected none (t=%0t)", k.name(), $time);
      return;
    end
    e = exp_q.pop_front();
    check({e.kind.name(), "_kind"}, int'(k), int'(e.kind));
    check({e.kind.name(), "_val"}, val, e.val);
    check({e.kind.name(), "_slip_cnt"}, slip_cnt, e.slip);
    check({e.kind.name(), "_relock_cnt"}, relock_cnt, e.relock);
    if (e.lat >= 0) check({e.kind.name(), "_latency"}, cyc - start_cyc, e.lat);
  endtask

  // Frame lane: one left rotation per observed bitslip pulse.
  initial forever begin
    @(negedge clk);
    if (bitslip === 1'b1) rot = (rot + 1) % 8;
    frame_word = corrupt ? 8'h00 : (aa_mode ? 8'hAA : rotl(base, rot));
  end

  // Monitor: turns output edges into events and compares them with the scoreboard.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bufr_clr) clr_w++;
      else if (p_clr) begin got(EV_CLR, clr_w); clr_w = 0; last_slip = -1; end
      if (bitslip) begin
        check("bitslip_single_cycle", p_slip, 0);
        if (!p_slip) begin
          if (last_slip >= 0) check("bitslip_gap_ok", (cyc - last_slip) > SETTLE_CYCLES, 1);
          last_slip = cyc;
          got(EV_SLIP, {locked, fail});
        end
      end
      if (locked && !p_lock) got(EV_LOCK, {locked, fail});
      if (fail && !p_fail)   got(EV_FAIL, {locked, fail});
      if (!locked && p_lock) got(EV_UNLOCK, {locked, fail});
    end else begin
      clr_w = 0;
      last_slip = -1;
    end
    p_clr = bufr_clr; p_slip = bitslip; p_lock = locked; p_fail = fail;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, hits;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // aligned lane: clear, settle, match, lock without slips
    do_start(PATTERN, 1'b0);
    wait_q(300, "aligned");
    check("aligned_locked", locked, 1);

    // lane three slips off
    do_start(8'h1E, 1'b0);
    wait_q(300, "off3");
    check("off3_slip_cnt", slip_cnt, 3);

    // random offsets
    repeat (4) begin
      k = $urandom_range(0, 7);
      do_start(rotl(PATTERN, 8 - k), 1'b0);
      wait_q(400, "random");
      check("random_slip_cnt", slip_cnt, k);
    end

    // unalignable lane: every slip used, then fail with no extra pulse
    do_start(PATTERN, 1'b1);
    wait_q(400, "aa");
    repeat (40) @(negedge clk);
    check("aa_fail", fail, 1);
    check("aa_locked", locked, 0);
    check("aa_slip_cnt", slip_cnt, MAX_SLIPS);

    // restart out of FAIL, then start again during the first SLIP cycle
    pulse_start(PATTERN, 1'b1);
    push(EV_CLR, CLR_CYCLES, 0, CLR_CYCLES);
    check("restart_fail_cleared", fail, 0);
    check("restart_slip_cnt", slip_cnt, 0);
    check("restart_bufr_clr", bufr_clr, 1);
    while (cyc < start_cyc + 2 * SETTLE_CYCLES && cyc < start_cyc + CLR_CYCLES + SETTLE_CYCLES)
      begin @(posedge clk); #1; end
    do_start(PATTERN, 1'b1);
    check("slipstart_no_bitslip", bitslip, 0);
    check("slipstart_bufr_clr", bufr_clr, 1);
    check("slipstart_slip_cnt", slip_cnt, 0);
    wait_q(400, "slipstart");

    // lock monitor
    do_start(PATTERN, 1'b0);
    wait_q(300, "mon_lock");
    feed(16'b0000_0011_1011, 12);  // 2 bad, 1 good, 3 bad, then good
    repeat (4) @(negedge clk);
    check("mon_short_burst_locked", locked, 1);
    check("mon_short_burst_relock", relock_cnt, 0);
`ifdef LTC2175_ALIGN_MONITOR_EN
    exp_relock = exp_relock + 1;
    push(EV_UNLOCK, 0, 0, -1);
    push(EV_LOCK, 2, 0, -1);
`endif
    feed(16'b1111, 4);
    @(posedge clk); #1;
    corrupt = 1'b0;
    @(negedge clk);
    check("mon_fourth_pending_locked", locked, 1);
    @(negedge clk);
`ifdef LTC2175_ALIGN_MONITOR_EN
    check("mon_limit_unlocked", locked, 0);
`else
    check("mon_limit_sticky", locked, 1);
`endif
    wait_q(300, "mon_relock");
    check("mon_relock_cnt", relock_cnt, exp_relock);
    check("mon_final_locked", locked, 1);

    // asynchronous reset in the middle of CLR
    mon_en = 1'b0;
    model_locked = 1'b0;
    pulse_start(PATTERN, 1'b0);
    @(negedge clk);
    check("rstclr_bufr_clr_high", bufr_clr, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid_clr");
    @(negedge clk);
    rst_n = 1'b1;
    exp_relock = 0;

    // asynchronous reset during a bitslip pulse
    pulse_start(8'h1E, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (bitslip !== 1'b1 && n < 200);
    check("rstslip_bitslip_seen", bitslip, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid_slip");
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bitslip || bufr_clr || locked) hits++;
    end
    check("rst_stays_idle", hits, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
